// File: rtl/led_pwm_io_pkg.sv
// rtl/led_pwm_io_pkg.sv - shared register offsets and defaults for the LED PWM peripheral
package led_pwm_io_pkg;

    typedef enum logic [1:0] {
        LED_REG_EN   = 2'd0,
        LED_REG_BLK  = 2'd1,
        LED_REG_DUTY = 2'd2,
        LED_REG_HALF = 2'd3
    } led_reg_e;

    localparam logic [15:0] LED_BASE_ID = 16'h002A;

endpackage

// File: rtl/led_blink_timer.sv
// rtl/led_blink_timer.sv - prescaled blink phase generator, half-period in ticks
module led_blink_timer #(
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [15:0] half,
    output logic        phase
);

    localparam int PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PSC_W-1:0] psc_q, psc_d;
    logic [15:0]      bcnt_q, bcnt_d;
    logic             phase_q, phase_d;
    logic             tick;

    always_comb begin
        tick    = (psc_q == PSC_W'(TICK_DIV - 1));
        psc_d   = tick ? '0 : psc_q + PSC_W'(1);
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (clear) begin
            psc_d   = '0;
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (half == 16'd0) begin
            // A zero half-period parks the LEDs in the lit phase.
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (tick) begin
            if (bcnt_q == half - 16'd1) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psc_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else begin
            psc_q   <= psc_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/led_pwm_io.sv
// rtl/led_pwm_io.sv - LED register file with global PWM brightness and per-LED blink
module led_pwm_io
    import led_pwm_io_pkg::*;
#(
    parameter int          NUM_LEDS = 8,
    parameter int          PWM_BITS = 4,
    parameter int          TICK_DIV = 50000,
    parameter logic [15:0] BASE_ID  = LED_BASE_ID
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write,
    input  logic                read,
    input  logic [15:0]         id,
    input  logic [15:0]         din,
    output logic [15:0]         dout,
    output logic [NUM_LEDS-1:0] ledsout
);

    logic [NUM_LEDS-1:0] en_q, en_d, blk_q, blk_d, leds_q, leds_d;
    logic [PWM_BITS-1:0] duty_q, duty_d, pcnt_q, pcnt_d;
    logic [15:0]         half_q, half_d, dout_q, dout_d, rd;
    logic [15:0]         rel;
    logic                hit, half_clear, pwm_on, phase;
    led_reg_e            sel;

    // Offset from the base: a hit needs the offset to fit in two bits.
    assign rel        = id - BASE_ID;
    assign hit        = (rel[15:2] == 14'd0);
    assign sel        = led_reg_e'(rel[1:0]);
    assign half_clear = write && hit && (sel == LED_REG_HALF);

    always_comb begin
        en_d   = en_q;
        blk_d  = blk_q;
        duty_d = duty_q;
        half_d = half_q;
        if (write && hit) begin
            case (sel)
                LED_REG_EN:   en_d   = din[NUM_LEDS-1:0];
                LED_REG_BLK:  blk_d  = din[NUM_LEDS-1:0];
                LED_REG_DUTY: duty_d = din[PWM_BITS-1:0];
                LED_REG_HALF: half_d = din;
                default:      ;
            endcase
        end
    end

    always_comb begin
        rd = '0;
        case (sel)
            LED_REG_EN:   rd[NUM_LEDS-1:0] = en_q;
            LED_REG_BLK:  rd[NUM_LEDS-1:0] = blk_q;
            LED_REG_DUTY: rd[PWM_BITS-1:0] = duty_q;
            LED_REG_HALF: rd               = half_q;
            default:      ;
        endcase
        dout_d = (read && hit) ? rd : 16'd0;
    end

    always_comb begin
        pcnt_d = pcnt_q + PWM_BITS'(1);
        pwm_on = (&duty_q) || (pcnt_q < duty_q);
        leds_d = en_q & {NUM_LEDS{pwm_on}} & (~blk_q | {NUM_LEDS{phase}});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q   <= '0;
            blk_q  <= '0;
            duty_q <= '1;
            half_q <= '0;
            pcnt_q <= '0;
            dout_q <= '0;
            leds_q <= '0;
        end else begin
            en_q   <= en_d;
            blk_q  <= blk_d;
            duty_q <= duty_d;
            half_q <= half_d;
            pcnt_q <= pcnt_d;
            dout_q <= dout_d;
            leds_q <= leds_d;
        end
    end

    led_blink_timer #(
        .TICK_DIV(TICK_DIV)
    ) u_blink (
        .clk  (clk),
        .reset(reset),
        .clear(half_clear),
        .half (half_q_next_sel()),
        .phase(phase)
    );

    function automatic logic [15:0] half_q_next_sel();
        return half_q;
    endfunction

    assign dout    = dout_q;
    assign ledsout = leds_q;

endmodule

// File: tb/tb_led_pwm_io.sv
// tb/tb_led_pwm_io.sv - directed self-checking bench for led_pwm_io
module tb_led_pwm_io;

    localparam logic [15:0] BASE = 16'h002A;

    logic        clk = 1'b0;
    logic        reset, write, read;
    logic [15:0] id, din, dout;
    logic [7:0]  ledsout;

    int n_checks = 0;
    int n_pass   = 0;

    led_pwm_io #(
        .NUM_LEDS(8),
        .PWM_BITS(4),
        .TICK_DIV(4),
        .BASE_ID (BASE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .write  (write),
        .read   (read),
        .id     (id),
        .din    (din),
        .dout   (dout),
        .ledsout(ledsout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    endtask

    // Returns at the falling edge after the write edge.
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        write = 1'b1; id = a; din = d;
        @(negedge clk);
        write = 1'b0; id = 16'd0; din = 16'd0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        read = 1'b1; id = a;
        @(negedge clk);
        read = 1'b0; id = 16'd0;
        d = dout;
    endtask

    task automatic count_high(input string tag, input int exp_high);
        int high = 0;
        int bad  = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (ledsout == 8'hFF) high++;
            else if (ledsout != 8'h00) bad++;
        end
        check({tag, "_high"}, 16'(high), 16'(exp_high));
        check({tag, "_mixed"}, 16'(bad), 16'd0);
    endtask

    logic [15:0] rv;
    logic [3:0]  exp_lo;
    bit          seen;

    initial begin
        reset = 1'b1; write = 1'b0; read = 1'b0; id = 16'd0; din = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_leds", {8'd0, ledsout}, 16'h0000);
        check("reset_dout", dout, 16'h0000);
        reset = 1'b0;

        // 1: legacy on/off with reset duty, then reset clears the output
        bus_write(BASE, 16'h00A5);
        check("t1_lat_edge1", {8'd0, ledsout}, 16'h0000);
        @(negedge clk);
        check("t1_lat_edge2", {8'd0, ledsout}, 16'h00A5);
        reset = 1'b1;
        @(negedge clk);
        check("t1_reset_leds", {8'd0, ledsout}, 16'h0000);
        reset = 1'b0;

        // 2: PWM duty
        bus_write(BASE, 16'h00FF);
        bus_write(BASE + 16'd2, 16'h0004);
        repeat (2) @(negedge clk);
        count_high("t2_duty4", 4);
        bus_write(BASE + 16'd2, 16'h0000);
        repeat (2) @(negedge clk);
        count_high("t2_duty0", 0);
        bus_write(BASE + 16'd2, 16'h000F);
        repeat (2) @(negedge clk);
        count_high("t2_dutyF", 16);

        // 3: blink with half=3 ticks of 4 clocks -> 12-cycle halves
        bus_write(BASE + 16'd1, 16'h000F);
        bus_write(BASE + 16'd3, 16'h0003);
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            exp_lo = ((((k - 1) / 12) % 2) == 0) ? 4'hF : 4'h0;
            check($sformatf("t3_lo_k%0d", k), {12'd0, ledsout[3:0]}, {12'd0, exp_lo});
            check($sformatf("t3_hi_k%0d", k), {12'd0, ledsout[7:4]}, 16'h000F);
        end

        // 4: half=0 parks high; half=2 toggles phase 8 edges after the write
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (ledsout[3:0] == 4'h0) seen = 1'b1;
        end
        check("t4_wait_low", {15'd0, seen}, 16'd1);
        bus_write(BASE + 16'd3, 16'h0000);
        @(negedge clk);
        check("t4_half0_high", {8'd0, ledsout}, 16'h00FF);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("t4_half0_hold%0d", i), {8'd0, ledsout}, 16'h00FF);
        end
        bus_write(BASE + 16'd3, 16'h0002);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("t4_half2_k%0d", k), {8'd0, ledsout}, (k <= 8) ? 16'h00FF : 16'h00F0);
        end

        // 5: read-back masking and address decode
        bus_write(BASE,          16'h01FF);
        bus_write(BASE + 16'd1,  16'h00F0);
        bus_write(BASE + 16'd2,  16'h0037);
        bus_write(BASE + 16'd3,  16'hBEEF);
        bus_read(BASE, rv);          check("t5_r0", rv, 16'h00FF);
        @(negedge clk);              check("t5_dout_idle", dout, 16'h0000);
        bus_read(BASE + 16'd1, rv);  check("t5_r1", rv, 16'h00F0);
        bus_read(BASE + 16'd2, rv);  check("t5_r2", rv, 16'h0007);
        bus_read(BASE + 16'd3, rv);  check("t5_r3", rv, 16'hBEEF);
        bus_read(BASE + 16'd4, rv);  check("t5_r4_unmapped", rv, 16'h0000);
        bus_write(16'h0029, 16'h0000);
        bus_read(BASE, rv);          check("t5_r0_after_0029", rv, 16'h00FF);
        bus_read(16'h0029, rv);      check("t5_read_0029", rv, 16'h0000);

        // 6: reset wins over a simultaneous write
        @(negedge clk);
        reset = 1'b1; write = 1'b1; id = BASE; din = 16'h00FF;
        @(negedge clk);
        reset = 1'b0; write = 1'b0; id = 16'd0; din = 16'd0;
        check("t6_leds_reset", {8'd0, ledsout}, 16'h0000);
        bus_read(BASE, rv);          check("t6_en_zero", rv, 16'h0000);
        bus_read(BASE + 16'd2, rv);  check("t6_duty_reset", rv, 16'h000F);
        bus_read(BASE + 16'd3, rv);  check("t6_half_reset", rv, 16'h0000);
        check("t6_leds_still0", {8'd0, ledsout}, 16'h0000);
        bus_write(BASE + 16'd1, 16'h00FF);
        bus_write(BASE, 16'h00FF);
        @(negedge clk);
        check("t6_phase_one", {8'd0, ledsout}, 16'h00FF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
